regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback sources: req0 (ALU result) and req1 (load/memory result). Each source uses a valid/ready handshake. The winning request is registered into one write stage that drives the register file's write port. Sits between the execute/memory stages and the 32x32 register file; the register-file write port takes an explicit write enable driven by this block.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register address
DROP_ZERO, 1, 1 = writes to register 0 are accepted but never reach the port

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
stall  in  1  1 = grant nothing this cycle
req0_valid  in  1  ALU writeback request
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req0_ready  out  1  ALU request accepted this cycle
req1_valid  in  1  load writeback request
req1_addr  in  ADDR_W  load destination register
req1_data  in  DATA_W  load result
req1_ready  out  1  load request accepted this cycle
wr_en  out  1  register-file write enable
wr_addr  out  ADDR_W  register-file write address
wr_data  out  DATA_W  register-file write data
conflict_cnt  out  16  saturating count of cycles where both requests were valid and not stalled

Behaviour:
- Reset (rst=1 at posedge):
  - wr_en=0, wr_addr=0, wr_data=0, conflict_cnt=0.
  - Priority pointer set to favour req0.
  - rst mid-operation discards the in-flight write stage (wr_en=0 next cycle).
  - req*_ready=0 during any cycle in which rst=1.
- Handshake:
  - reqN_ready is combinational from valid, stall and the priority pointer.
  - A transfer occurs when valid & ready at a posedge.
  - Requesters hold addr/data stable while valid & !ready.
  - Ready never depends on ready itself; valid may not depend on ready.
- Arbitration (one grant per cycle max):
  - stall=1 → both ready=0; pointer unchanged.
  - Exactly one valid → that one is granted.
  - Both valid → the pointer's favourite is granted, then the pointer flips to the other source (round robin). A single uncontested grant leaves the pointer pointing away from the winner.
  - Priority FSM states: PRI0, PRI1.
    - PRI0 → PRI1 on any req0 grant.
    - PRI1 → PRI0 on any req1 grant.
    - Otherwise hold.
- Write stage:
  - A grant at posedge t loads wr_addr/wr_data at t, and wr_en=1 for the cycle following t (1-cycle latency).
  - No grant → wr_en=0; wr_addr/wr_data hold their previous values.
- Register 0: if DROP_ZERO=1 and the granted addr=0, the grant still completes (ready=1) and the pointer still updates, but wr_en=0.
- conflict_cnt:
  - Increments at a posedge where both valid and stall=0 and rst=0.
  - Saturates at 16'hFFFF (no wrap).
- Maximum wait: a continuously valid requester is granted within 2 unstalled cycles.

Optional Feature:
WB_FWD_EN
- Defined: adds inputs rd_addr1/rd_addr2 (ADDR_W) and outputs fwd_hit1/fwd_hit2 (1) and fwd_data1/fwd_data2 (DATA_W).
  - fwd_hitK = wr_en & (wr_addr==rd_addrK) & (rd_addrK!=0).
  - fwd_dataK = wr_data when hit, else 0.
  - All combinational from the write stage, so readers see the in-flight write.
- Undefined: the ports do not exist and no compare logic is built.

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0
  - enum pri_state_t {PRI0, PRI1}
  - CONFLICT_CNT_W=16
- One natural sub-module: rr_arbiter2, the 2-way round-robin grant plus pointer FSM with a stall input. The write stage, zero-drop and counter stay in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then no valids → wr_en=0, conflict_cnt=0, both ready=0.
- Single source: req0 valid, addr=5, data=0xDEADBEEF for 1 cycle → req0_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; cycle after, wr_en=0.
- Contention: both valid for 4 cycles (req0 addr=1/data=0x11, req1 addr=2/data=0x22), held until accepted then deasserted → grants in order req0, req1; wr_addr sequence 1,2; conflict_cnt=1.
- Stall: both valid with stall=1 for 3 cycles, then stall=0 → no ready and wr_en=0 while stalled; conflict_cnt unchanged until unstall; first grant goes to the pre-stall favourite.
- Zero register: req1 valid, addr=0, data=0xFFFFFFFF → req1_ready=1, wr_en stays 0, pointer flips to PRI0. With WB_FWD_EN, also drive rd_addr1=3 while the write stage holds addr 3 → fwd_hit1=1 with matching fwd_data1.
- Saturation and reset mid-write: force conflict_cnt to 0xFFFE (hierarchical deposit) and run 3 conflict cycles → counter stops at 0xFFFF. Assert rst in the cycle a grant occurs → next cycle wr_en=0 and conflict_cnt=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: types and constants shared by the register-file writeback path.
//   REG_ADDR_W / REG_DATA_W : default register address and data widths (32x32 file)
//   REG_ZERO                : architectural zero register index
//   CONFLICT_CNT_W          : width of the contention statistics counter
//   pri_state_t             : round-robin priority pointer (PRI0 favours req0)
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int CONFLICT_CNT_W = 16;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with a stall input.
//   clk, rst        : clock and synchronous active-high reset (pointer -> PRI0)
//   stall           : 1 = grant nothing, pointer holds
//   valid0, valid1  : request lines
//   grant0, grant1  : one-hot (or zero) grant, combinational from valid/stall/pointer
// The pointer moves away from whichever source was granted, so a source that
// keeps its request up is served within two unstalled cycles.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  pri_state_t state_reg;
  pri_state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= PRI0;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_next = state_reg;
    // No grants while reset is asserted so nothing is accepted into a stage
    // that is being cleared.
    if (!rst && !stall) begin
      case (state_reg)
        PRI0: begin
          grant0 = valid0;
          grant1 = valid1 & ~valid0;
        end
        PRI1: begin
          grant1 = valid1;
          grant0 = valid0 & ~valid1;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
    if (grant0) begin
      state_next = PRI1;
    end else if (grant1) begin
      state_next = PRI0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the ALU
// writeback (req0) and the load writeback (req1).
//   clk, rst                      : clock, synchronous active-high reset
//   stall                         : 1 = accept nothing this cycle
//   req0_valid/addr/data, req0_ready : ALU writeback handshake
//   req1_valid/addr/data, req1_ready : load writeback handshake
//   wr_en, wr_addr, wr_data       : registered write port (1-cycle latency)
//   conflict_cnt                  : saturating count of unstalled both-valid cycles
// Optional macro WB_FWD_EN adds rd_addr1/rd_addr2 inputs and fwd_hit1/2,
// fwd_data1/2 outputs that expose the in-flight write to register readers.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W    = REG_DATA_W,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DROP_ZERO = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      req0_valid,
  input  logic [ADDR_W-1:0]         req0_addr,
  input  logic [DATA_W-1:0]         req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [ADDR_W-1:0]         req1_addr,
  input  logic [DATA_W-1:0]         req1_data,
  output logic                      req1_ready,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      fwd_hit1,
  output logic                      fwd_hit2,
  output logic [DATA_W-1:0]         fwd_data1,
  output logic [DATA_W-1:0]         fwd_data2,
`endif
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

  logic grant0;
  logic grant1;
  logic grant_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic sel_is_zero;

  logic                      wr_en_reg;
  logic [ADDR_W-1:0]         wr_addr_reg;
  logic [DATA_W-1:0]         wr_data_reg;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_reg;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign grant_any  = grant0 | grant1;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;
  // Zero-register writes complete the handshake but are suppressed at the port.
  assign sel_is_zero = (DROP_ZERO != 0) && (sel_addr == ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_reg        <= 1'b0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      wr_en_reg <= grant_any & ~sel_is_zero;
      if (grant_any) begin
        wr_addr_reg <= sel_addr;
        wr_data_reg <= sel_data;
      end
      if (req0_valid && req1_valid && !stall && (conflict_cnt_reg != '1)) begin
        conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
      end
    end
  end

  assign wr_en        = wr_en_reg;
  assign wr_addr      = wr_addr_reg;
  assign wr_data      = wr_data_reg;
  assign conflict_cnt = conflict_cnt_reg;

`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] rd_addr_arr  [2];
  logic              fwd_hit_arr  [2];
  logic [DATA_W-1:0] fwd_data_arr [2];

  assign rd_addr_arr[0] = rd_addr1;
  assign rd_addr_arr[1] = rd_addr2;

  // Register 0 never forwards: it always reads as zero from the file itself.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_hit_arr[gi]  = wr_en_reg && (wr_addr_reg == rd_addr_arr[gi]) &&
                              (rd_addr_arr[gi] != ADDR_W'(REG_ZERO));
    assign fwd_data_arr[gi] = fwd_hit_arr[gi] ? wr_data_reg : '0;
  end

  assign fwd_hit1  = fwd_hit_arr[0];
  assign fwd_hit2  = fwd_hit_arr[1];
  assign fwd_data1 = fwd_data_arr[0];
  assign fwd_data2 = fwd_data_arr[1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a cycle-level reference model
// of the arbiter and write stage, plus literal expectations at key points.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] conflict_cnt;
`ifdef WB_FWD_EN
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
`ifdef WB_FWD_EN
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2),
`endif
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .conflict_cnt (conflict_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: favourite source, expected write stage and counter.
  bit          m_ok = 1'b0;
  int          m_fav = 0;
  bit          m_en = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_cnt = 0;

  always @(negedge clk) begin
    bit g0;
    bit g1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && !stall) begin
      if (req0_valid && req1_valid) begin
        if (m_fav == 0) g0 = 1'b1;
        else            g1 = 1'b1;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    if (m_ok || rst) begin
      chk("model_req0_ready", req0_ready, g0);
      chk("model_req1_ready", req1_ready, g1);
    end
    if (m_ok) begin
      chk("model_wr_en", wr_en, m_en);
      chk("model_wr_addr", wr_addr, m_addr);
      chk("model_wr_data", wr_data, m_data);
      chk("model_conflict_cnt", conflict_cnt, m_cnt);
`ifdef WB_FWD_EN
      chk("model_fwd_hit1", fwd_hit1, m_en && m_addr == rd_addr1 && rd_addr1 != 0);
      chk("model_fwd_data1", fwd_data1,
          (m_en && m_addr == rd_addr1 && rd_addr1 != 0) ? m_data : 32'd0);
      chk("model_fwd_hit2", fwd_hit2, m_en && m_addr == rd_addr2 && rd_addr2 != 0);
      chk("model_fwd_data2", fwd_data2,
          (m_en && m_addr == rd_addr2 && rd_addr2 != 0) ? m_data : 32'd0);
`endif
    end
    // Advance the model to the state after the coming posedge.
    if (rst) begin
      m_ok = 1'b1; m_fav = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
    end else if (m_ok) begin
      if (req0_valid && req1_valid && !stall && m_cnt < 65535) m_cnt++;
      m_en = 1'b0;
      if (g0) begin
        m_addr = req0_addr; m_data = req0_data; m_en = (req0_addr != 0); m_fav = 1;
      end else if (g1) begin
        m_addr = req1_addr; m_data = req1_data; m_en = (req1_addr != 0); m_fav = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    int gseq [2];
    logic [4:0] aseq [2];
    int n;
    logic g0s;
    logic g1s;

    // Reset then idle
    rst = 1'b1; idle(); cyc(); cyc(); rst = 1'b0;
    cyc();
    chk("reset_wr_en", wr_en, 0);
    chk("reset_cnt", conflict_cnt, 0);
    chk("reset_ready0", req0_ready, 0);
    chk("reset_ready1", req1_ready, 0);

    // Single source
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1 chk("single_ready0", req0_ready, 1);
    cyc(); idle();
    chk("single_wr_en", wr_en, 1);
    chk("single_wr_addr", wr_addr, 5);
    chk("single_wr_data", wr_data, 32'hDEADBEEF);
    cyc();
    chk("single_wr_en_off", wr_en, 0);

    // Contention from a fresh pointer
    rst = 1'b1; cyc(); rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
    n = 0;
    gseq[0] = 9; gseq[1] = 9; aseq[0] = '0; aseq[1] = '0;
    for (int i = 0; i < 4 && (req0_valid || req1_valid); i++) begin
      #1;
      g0s = req0_ready; g1s = req1_ready;
      cyc();
      if (g0s) begin
        req0_valid = 1'b0;
        if (n < 2) begin gseq[n] = 0; aseq[n] = wr_addr; end
        n++;
      end
      if (g1s) begin
        req1_valid = 1'b0;
        if (n < 2) begin gseq[n] = 1; aseq[n] = wr_addr; end
        n++;
      end
    end
    chk("contention_grant_count", n, 2);
    chk("contention_first", gseq[0], 0);
    chk("contention_second", gseq[1], 1);
    chk("contention_addr_first", aseq[0], 1);
    chk("contention_addr_second", aseq[1], 2);
    chk("contention_cnt", conflict_cnt, 1);
    idle();

    // Stall: pointer currently favours req0
    stall = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready0", req0_ready, 0);
      chk("stall_ready1", req1_ready, 0);
      cyc();
      chk("stall_wr_en", wr_en, 0);
      chk("stall_cnt", conflict_cnt, 1);
    end
    stall = 1'b0;
    #1;
    chk("unstall_ready0", req0_ready, 1);
    chk("unstall_ready1", req1_ready, 0);
    cyc(); req0_valid = 1'b0;
    chk("unstall_wr_addr", wr_addr, 7);
    chk("unstall_cnt", conflict_cnt, 2);
    cyc(); idle();
    chk("unstall_second_addr", wr_addr, 8);

    // Zero register (and forwarding of an in-flight write)
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    cyc(); idle();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
`ifdef WB_FWD_EN
    rd_addr1 = 5'd3; rd_addr2 = 5'd0;
    #1;
    chk("fwd_hit1", fwd_hit1, 1);
    chk("fwd_data1", fwd_data1, 32'h33);
    chk("fwd_hit2_zero", fwd_hit2, 0);
`else
    #1;
`endif
    chk("zero_ready1", req1_ready, 1);
    cyc(); idle();
    chk("zero_wr_en", wr_en, 0);
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    #1;
    chk("zero_ptr_ready0", req0_ready, 1);
    chk("zero_ptr_ready1", req1_ready, 0);
    idle();
    cyc();

    // Saturation: hold both sources for more than 65535 unstalled cycles
    rst = 1'b1; cyc(); rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h99;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hAA;
    repeat (65540) cyc();
    chk("saturate_cnt", conflict_cnt, 16'hFFFF);

    // Reset in a cycle that would otherwise grant
    rst = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_inflight_wr_en", wr_en, 1);
    cyc(); rst = 1'b0; idle();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_cnt", conflict_cnt, 0);
    cyc();
    chk("post_rst_wr_en", wr_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
